// File: rtl/synth_pkg.sv
// Shared constants and FSM encoding for the I2S frame scheduler.
// Default voice count and sample width, plus the scheduler state type.
package synth_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int NUM_VOICES = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    COLLECT    = 2'd1,
    WAIT_FRAME = 2'd2,
    LOAD       = 2'd3
  } state_e;

endpackage

// File: rtl/sat_clamp.sv
// Signed saturating narrower: clamps a wide signed value into OUT_W bits.
// Ports: d_i wide signed input, q_o clamped signed output.
module sat_clamp #(
  parameter int IN_W  = 18,
  parameter int OUT_W = 16
) (
  input  logic signed [IN_W-1:0]  d_i,
  output logic signed [OUT_W-1:0] q_o
);

  if (IN_W > OUT_W) begin : g_clamp
    logic [IN_W-OUT_W:0] top;
    logic                ovf;

    // Value fits only when every bit above the
    // output sign bit replicates that sign bit.
    assign top = d_i[IN_W-1:OUT_W-1];
    assign ovf = !((&top) || !(|top));

    always_comb begin
      q_o = d_i[OUT_W-1:0];
      if (ovf) begin
        if (d_i[IN_W-1]) begin
          q_o = {1'b1, {(OUT_W-1){1'b0}}};
        end else begin
          q_o = {1'b0, {(OUT_W-1){1'b1}}};
        end
      end
    end
  end else begin : g_pass
    assign q_o = OUT_W'(d_i);
  end

endmodule

// File: rtl/i2s_frame_scheduler.sv
// Collects one sample per voice, pans and mixes into L/R, and hands the
// saturated mix to the I2S controller on each frame_clk rising edge.
// Ports: clk, reset (async, active-low), enable, voice_sample/valid/ready
// (per-voice handshake, voice i in slice i), pan (2 bits per voice: L,R),
// frame_clk, send (1-cycle load strobe), sample_left/right, underrun
// (sticky missed deadline) and underrun_clr.
module i2s_frame_scheduler #(
  parameter int NUM_VOICES = synth_pkg::NUM_VOICES,
  parameter int SAMPLE_W   = synth_pkg::SAMPLE_W
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  input  logic [NUM_VOICES-1:0]          voice_valid,
  output logic [NUM_VOICES-1:0]          voice_ready,
  input  logic [2*NUM_VOICES-1:0]        pan,
  input  logic                           frame_clk,
  output logic                           send,
  output logic [SAMPLE_W-1:0]            sample_left,
  output logic [SAMPLE_W-1:0]            sample_right,
  output logic                           underrun,
  input  logic                           underrun_clr
);

  import synth_pkg::*;

  localparam int IDX_W =
    (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int ACC_W =
    SAMPLE_W + $clog2(NUM_VOICES);

  state_e state_q, state_d;

  logic [IDX_W-1:0] idx_q, idx_d;

  logic signed [ACC_W-1:0] accl_q, accl_d;
  logic signed [ACC_W-1:0] accr_q, accr_d;

  logic fclk_q;
  logic frame_tick;

  logic und_q, und_d;

  logic [SAMPLE_W-1:0] sl_q, sr_q;
  logic [SAMPLE_W-1:0] sat_l, sat_r;

  logic load_d;
  logic hs;
  logic last;

  logic signed [SAMPLE_W-1:0] smp [NUM_VOICES];
  logic [NUM_VOICES-1:0]      pan_l, pan_r;
  logic signed [SAMPLE_W-1:0] cur_s;

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_voice
    assign smp[g]   = voice_sample[g*SAMPLE_W +: SAMPLE_W];
    assign pan_l[g] = pan[2*g];
    assign pan_r[g] = pan[2*g+1];
  end

  assign cur_s      = smp[idx_q];
  assign last       = (idx_q == IDX_W'(NUM_VOICES-1));
  assign frame_tick = frame_clk & ~fclk_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    accl_d      = accl_q;
    accr_d      = accr_q;
    und_d       = und_q & ~underrun_clr;
    voice_ready = '0;
    hs          = 1'b0;

    if (!enable) begin
      state_d = IDLE;
      idx_d   = '0;
      accl_d  = '0;
      accr_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = COLLECT;
          idx_d   = '0;
          accl_d  = '0;
          accr_d  = '0;
        end

        COLLECT: begin
          voice_ready[idx_q] = 1'b1;
          hs = voice_valid[idx_q];
          if (hs) begin
            if (pan_l[idx_q]) begin
              accl_d = accl_q + ACC_W'(cur_s);
            end
            if (pan_r[idx_q]) begin
              accr_d = accr_q + ACC_W'(cur_s);
            end
            idx_d = last ? '0 : idx_q + IDX_W'(1);
          end
          // A last-voice handshake on the tick edge
          // still completes the frame in time.
          if (frame_tick) begin
            state_d = LOAD;
            if (!(hs && last)) begin
              und_d = 1'b1;
            end
          end else if (hs && last) begin
            state_d = WAIT_FRAME;
          end
        end

        WAIT_FRAME: begin
          if (frame_tick) begin
            state_d = LOAD;
          end
        end

        LOAD: begin
          state_d = COLLECT;
          idx_d   = '0;
          accl_d  = '0;
          accr_d  = '0;
        end

        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Outputs are captured on the edge entering LOAD
  // so they are already valid while send is high.
  assign load_d = (state_d == LOAD);

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_sat_l (
    .d_i (accl_d),
    .q_o (sat_l)
  );

  sat_clamp #(
    .IN_W  (ACC_W),
    .OUT_W (SAMPLE_W)
  ) u_sat_r (
    .d_i (accr_d),
    .q_o (sat_r)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= '0;
      accl_q  <= '0;
      accr_q  <= '0;
      fclk_q  <= 1'b0;
      und_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      accl_q  <= accl_d;
      accr_q  <= accr_d;
      fclk_q  <= frame_clk;
      und_q   <= und_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sl_q <= '0;
      sr_q <= '0;
    end else if (load_d) begin
      sl_q <= sat_l;
      sr_q <= sat_r;
    end
  end

  assign send         = (state_q == LOAD);
  assign sample_left  = sl_q;
  assign sample_right = sr_q;
  assign underrun     = und_q;

endmodule

// File: tb/tb_i2s_frame_scheduler.sv
// Scoreboard bench for i2s_frame_scheduler: frames are issued with
// expected mixes queued; a negedge monitor checks every send.
module tb_i2s_frame_scheduler;

  localparam int NV = 4;
  localparam int SW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  logic frame_clk = 1'b0;
  logic underrun_clr = 1'b0;
  logic [NV*SW-1:0] voice_sample = '0;
  logic [NV-1:0] voice_valid = '0;
  logic [2*NV-1:0] pan = '0;
  logic [NV-1:0] voice_ready;
  logic send;
  logic underrun;
  logic [SW-1:0] sample_left;
  logic [SW-1:0] sample_right;

  i2s_frame_scheduler #(
    .NUM_VOICES (NV),
    .SAMPLE_W   (SW)
  ) dut (
    .clk          (clk),
    .reset        (rst_n),
    .enable       (enable),
    .voice_sample (voice_sample),
    .voice_valid  (voice_valid),
    .voice_ready  (voice_ready),
    .pan          (pan),
    .frame_clk    (frame_clk),
    .send         (send),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  typedef struct {
    int l;
    int r;
    int u;
    int due;
  } exp_t;

  exp_t exp_q[$];
  int last_l = 0;
  int last_r = 0;
  int und_model = 0;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask

  function automatic int sat(input int v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic int sval(input logic [SW-1:0] x);
    return int'($signed(x));
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: checks reset values, ready one-hot, output hold
  // between sends, and every send against the queued mix.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      chk("rst_send", int'(send), 0);
      chk("rst_ready", int'(voice_ready), 0);
      chk("rst_left", sval(sample_left), 0);
      chk("rst_right", sval(sample_right), 0);
      chk("rst_underrun", int'(underrun), 0);
      last_l = 0;
      last_r = 0;
    end else begin
      chk("ready_onehot0", int'($onehot0(voice_ready)), 1);
      if (send) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_send actual=1 required=0 cyc=%0d",
                   cyc);
        end else begin
          e = exp_q.pop_front();
          chk("send_cycle", cyc, e.due);
          chk("left", sval(sample_left), e.l);
          chk("right", sval(sample_right), e.r);
          chk("underrun", int'(underrun), e.u);
          last_l = e.l;
          last_r = e.r;
        end
      end else begin
        chk("hold_left", sval(sample_left), last_l);
        chk("hold_right", sval(sample_right), last_r);
        if (exp_q.size() > 0 && cyc >= exp_q[0].due) begin
          tests++;
          fails++;
          $display("FAIL missed_send actual=0 required=1 due=%0d",
                   exp_q[0].due);
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // One frame: present samples, let the collection settle,
  // then raise frame_clk. coin holds voice 3 back until the
  // tick cycle so its handshake lands on the tick edge.
  task automatic run_frame(input int s[NV],
                           input logic [NV-1:0] vmask,
                           input logic [2*NV-1:0] pn,
                           input bit coin);
    exp_t e;
    int k;
    int l;
    int r;
    for (int i = 0; i < NV; i++) begin
      voice_sample[i*SW +: SW] = s[i][SW-1:0];
    end
    pan = pn;
    voice_valid = coin ? (vmask & 4'b0111) : vmask;
    step(8);
    k = 0;
    while (k < NV && vmask[k]) k++;
    l = 0;
    r = 0;
    for (int i = 0; i < k; i++) begin
      if (pn[2*i]) l += s[i];
      if (pn[2*i+1]) r += s[i];
    end
    if (k < NV) und_model = 1;
    e.l = sat(l);
    e.r = sat(r);
    e.u = und_model;
    e.due = cyc + 1;
    exp_q.push_back(e);
    frame_clk = 1'b1;
    voice_valid = coin ? 4'b1000 : 4'b0000;
    step(1);
    voice_valid = '0;
    step(1);
    frame_clk = 1'b0;
    step(2);
  endtask

  task automatic clear_underrun();
    underrun_clr = 1'b1;
    step(1);
    underrun_clr = 1'b0;
    und_model = 0;
    chk("underrun_clr", int'(underrun), 0);
  endtask

  initial begin
    int sv[NV];
    logic [NV-1:0] vm;
    bit coin;

    step(3);
    rst_n = 1'b1;
    enable = 1'b1;
    step(2);

    sv = '{100, 200, -50, 7};
    run_frame(sv, 4'hF, 8'hFF, 1'b0);

    sv = '{1000, -300, 0, 0};
    run_frame(sv, 4'hF, 8'b1111_1001, 1'b0);

    sv = '{20000, 20000, 20000, 20000};
    run_frame(sv, 4'hF, 8'hFF, 1'b0);

    sv = '{-20000, -20000, -20000, -20000};
    run_frame(sv, 4'hF, 8'hFF, 1'b0);

    sv = '{11, 22, 33, 44};
    run_frame(sv, 4'b1011, 8'hFF, 1'b0);

    clear_underrun();

    sv = '{1, 2, 3, 4};
    run_frame(sv, 4'hF, 8'hFF, 1'b1);

    // Abort a partial mix with enable low.
    sv = '{500, 600, 700, 800};
    for (int i = 0; i < NV; i++) begin
      voice_sample[i*SW +: SW] = sv[i][SW-1:0];
    end
    voice_valid = 4'b0011;
    step(5);
    enable = 1'b0;
    step(3);
    voice_valid = '0;
    enable = 1'b1;
    step(3);

    sv = '{-5, 9, 300, -1};
    run_frame(sv, 4'hF, 8'b0110_1110, 1'b0);

    // Reset in the middle of a collection.
    voice_valid = 4'b0011;
    step(5);
    rst_n = 1'b0;
    voice_valid = '0;
    und_model = 0;
    step(3);
    rst_n = 1'b1;
    step(6);

    sv = '{123, -456, 789, -1011};
    run_frame(sv, 4'hF, 8'hFF, 1'b0);

    for (int n = 0; n < 25; n++) begin
      for (int i = 0; i < NV; i++) begin
        sv[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      vm = 4'hF;
      coin = 1'b0;
      if ($urandom_range(0, 3) == 0) begin
        vm = 4'($urandom_range(0, 15));
      end else if ($urandom_range(0, 3) == 0) begin
        coin = 1'b1;
      end
      run_frame(sv, vm, 8'($urandom_range(0, 255)), coin);
      if (und_model != 0 && $urandom_range(0, 1) == 1) begin
        clear_underrun();
      end
    end

    step(5);
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain actual=%0d required=0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
